// File: rtl/test_ram_responder.sv
// ---------------------------------------------------------------------------
// test_ram_responder
//
// Bus slave that implements the TEST_RAM window of the system address map.
// It answers single-word read and write requests coming from any bus master
// through the interconnect. Storage is an on-chip RAM of SIZE 16-bit words.
// Accesses that fall outside the window, and writes with no byte enables,
// complete with an error response. An optional, fixed number of wait states
// delays every response so masters can exercise timeout and stall handling.
//
// Parameters:
//   BASE_ADDR   - first word address of the window
//   SIZE        - window size in words (power of two, 2..4096)
//   ADDR_W      - bus word-address width
//   DATA_W      - bus data width (16)
//   WAIT_STATES - extra cycles before every response (0..15)
//
// Ports:
//   clk      in   - single clock, rising edge
//   rst_n    in   - asynchronous active-low reset
//   m_req    in   - request, held by the master until it sees s_ack
//   m_we     in   - 1 = write, 0 = read
//   m_addr   in   - absolute word address
//   m_wdata  in   - write data
//   m_be     in   - byte enables, bit 0 = [7:0], bit 1 = [15:8]
//   s_ack    out  - one-cycle response strobe
//   s_rdata  out  - read data, valid with s_ack, held until next response
//   s_err    out  - error flag, qualified by s_ack, held until next response
//   busy     out  - high whenever the responder is not idle
// ---------------------------------------------------------------------------
module test_ram_responder #(
  parameter int BASE_ADDR   = 8192,
  parameter int SIZE        = 256,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic [1:0]        m_be,
  output logic              s_ack,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_err,
  output logic              busy
);

  localparam int                IDX_W   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] SIZE_A  = ADDR_W'(SIZE);
  localparam logic [3:0]        WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_READ = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        ws_cnt;
  logic [3:0]        ws_cnt_nxt;

  logic              lat_we;
  logic              lat_hit;
  logic [IDX_W-1:0]  lat_idx;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0]        lat_be;

  logic [ADDR_W-1:0] req_off;
  logic              req_hit;
  logic [IDX_W-1:0]  req_idx;

  logic              cur_we;
  logic              cur_hit;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] cur_wdata;
  logic [1:0]        cur_be;

  logic              enter_resp;
  logic              wr_en;
  logic              rd_en;
  logic              resp_err;

  logic [DATA_W-1:0] mem [SIZE];
  logic [DATA_W-1:0] ram_q;
  logic              rd_valid;
  logic              err_q;

  // Window decode of the live request. The offset wraps at ADDR_W bits, so
  // the explicit lower-bound test is what rejects addresses below the base.
  always_comb begin
    req_off = m_addr - BASE_A;
    req_hit = (m_addr >= BASE_A) && (req_off < SIZE_A);
    req_idx = req_off[IDX_W-1:0];
  end

  // With no wait states the RAM write happens on the very edge that samples
  // the request, before the latches hold it, so the live bus is used in IDLE
  // and the latched copy everywhere else.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_we    = m_we;
      cur_hit   = req_hit;
      cur_idx   = req_idx;
      cur_wdata = m_wdata;
      cur_be    = m_be;
    end else begin
      cur_we    = lat_we;
      cur_hit   = lat_hit;
      cur_idx   = lat_idx;
      cur_wdata = lat_wdata;
      cur_be    = lat_be;
    end
  end

  // Next-state logic. WAIT counts down from WAIT_STATES-1 and leaves when the
  // counter reads zero; only a read hit goes through READ, since it needs the
  // extra cycle of the synchronous RAM.
  always_comb begin
    state_nxt  = state;
    ws_cnt_nxt = ws_cnt;
    case (state)
      ST_IDLE: begin
        if (m_req) begin
          if (WAIT_STATES > 0) begin
            state_nxt  = ST_WAIT;
            ws_cnt_nxt = WS_LOAD;
          end else if (!m_we && req_hit) begin
            state_nxt = ST_READ;
          end else begin
            state_nxt = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (ws_cnt == 4'd0) begin
          state_nxt = (!lat_we && lat_hit) ? ST_READ : ST_RESP;
        end else begin
          ws_cnt_nxt = ws_cnt - 4'd1;
        end
      end
      ST_READ: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Response decode. The write is gated by rst_n so that a request seen while
  // reset is held can never touch the RAM; an in-flight write therefore lands
  // whole on the current edge or not at all.
  always_comb begin
    enter_resp = (state_nxt == ST_RESP) && (state != ST_RESP);
    wr_en      = rst_n && enter_resp && (state != ST_READ) &&
                 cur_we && cur_hit && (cur_be != 2'b00);
    rd_en      = (state == ST_READ);
    resp_err   = !cur_hit || (cur_we && (cur_be == 2'b00));
  end

  // State register, request latches and response flags. Only these are
  // cleared by reset; the RAM below deliberately keeps its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ws_cnt    <= 4'd0;
      lat_we    <= 1'b0;
      lat_hit   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_be    <= 2'b00;
      rd_valid  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      ws_cnt <= ws_cnt_nxt;
      if ((state == ST_IDLE) && m_req) begin
        lat_we    <= m_we;
        lat_hit   <= req_hit;
        lat_idx   <= req_idx;
        lat_wdata <= m_wdata;
        lat_be    <= m_be;
      end
      if (enter_resp) begin
        if (state == ST_READ) begin
          rd_valid <= 1'b1;
          err_q    <= 1'b0;
        end else begin
          rd_valid <= 1'b0;
          err_q    <= resp_err;
        end
      end
    end
  end

  // Byte-masked synchronous RAM with a registered read port. The read
  // register only updates in READ, so it also holds the last read data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (cur_be[0]) begin
        mem[cur_idx][7:0] <= cur_wdata[7:0];
      end
      if (cur_be[1]) begin
        mem[cur_idx][15:8] <= cur_wdata[15:8];
      end
    end
    if (rd_en) begin
      ram_q <= mem[lat_idx];
    end
  end

  // Outputs are decodes of registers only. s_rdata reads zero after a write,
  // a miss or reset, and otherwise shows the held RAM read register.
  always_comb begin
    s_ack   = (state == ST_RESP);
    busy    = (state != ST_IDLE);
    s_err   = err_q;
    s_rdata = rd_valid ? ram_q : '0;
  end

endmodule

// File: tb/tb_test_ram_responder.sv
module tb_test_ram_responder;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        rst_n0 = 1'b1, m_req0 = 1'b0, m_we0 = 1'b0;
  logic [15:0] m_addr0 = '0, m_wdata0 = '0;
  logic [1:0]  m_be0 = '0;
  logic        s_ack0, s_err0, busy0;
  logic [15:0] s_rdata0;

  logic        rst_n3 = 1'b1, m_req3 = 1'b0, m_we3 = 1'b0;
  logic [15:0] m_addr3 = '0, m_wdata3 = '0;
  logic [1:0]  m_be3 = '0;
  logic        s_ack3, s_err3, busy3;
  logic [15:0] s_rdata3;

  // Clock and cycle counter; cyc is the index of the most recent rising edge
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  test_ram_responder #(.BASE_ADDR(8192), .SIZE(256), .ADDR_W(16), .DATA_W(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .m_req(m_req0), .m_we(m_we0), .m_addr(m_addr0),
    .m_wdata(m_wdata0), .m_be(m_be0), .s_ack(s_ack0), .s_rdata(s_rdata0),
    .s_err(s_err0), .busy(busy0));

  test_ram_responder #(.BASE_ADDR(8192), .SIZE(256), .ADDR_W(16), .DATA_W(16), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n3), .m_req(m_req3), .m_we(m_we3), .m_addr(m_addr3),
    .m_wdata(m_wdata3), .m_be(m_be3), .s_ack(s_ack3), .s_rdata(s_rdata3),
    .s_err(s_err3), .busy(busy3));

  // Reference model: a word array per instance plus the timing of the one
  // outstanding transaction and the held response values before/after it
  logic [15:0] mmem [2][256];
  int          t_start [2];
  int          t_ack [2];
  logic [15:0] r_rdata [2];
  logic [15:0] p_rdata [2];
  logic        r_err [2];
  logic        p_err [2];

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic void model_reset(input int d);
    t_start[d] = -1;
    t_ack[d]   = -1;
    r_rdata[d] = '0;
    p_rdata[d] = '0;
    r_err[d]   = 1'b0;
    p_err[d]   = 1'b0;
  endfunction

  function automatic void model_issue(input int d, input logic we, input int addr,
                                      input logic [15:0] wd, input logic [1:0] be, input int e0);
    bit hit;
    int idx;
    hit = (addr >= 8192) && (addr < 8192 + 256);
    idx = addr - 8192;
    p_rdata[d] = r_rdata[d];
    p_err[d]   = r_err[d];
    t_start[d] = e0;
    if (!hit) begin
      r_rdata[d] = '0;
      r_err[d]   = 1'b1;
      t_ack[d]   = e0 + wait_of(d);
    end else if (we) begin
      r_rdata[d] = '0;
      r_err[d]   = (be == 2'b00);
      if (be[0]) mmem[d][idx][7:0] = wd[7:0];
      if (be[1]) mmem[d][idx][15:8] = wd[15:8];
      t_ack[d]   = e0 + wait_of(d);
    end else begin
      r_rdata[d] = mmem[d][idx];
      r_err[d]   = 1'b0;
      t_ack[d]   = e0 + wait_of(d) + 1;
    end
  endfunction

  // Single comparison primitive shared by the literal checks and the monitor
  task automatic checkOutput(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int  c;
      bit  e_busy, e_ack, done;
      int  e_rd, e_er;
      c      = cyc;
      e_busy = (t_start[d] >= 0) && (c >= t_start[d]) && (c <= t_ack[d]);
      e_ack  = (t_ack[d] >= 0) && (c == t_ack[d]);
      done   = (t_ack[d] >= 0) && (c >= t_ack[d]);
      e_rd   = done ? int'(r_rdata[d]) : int'(p_rdata[d]);
      e_er   = done ? int'(r_err[d]) : int'(p_err[d]);
      checkOutput($sformatf("d%0d_ack_c%0d", d, c), (d == 0) ? int'(s_ack0) : int'(s_ack3), int'(e_ack));
      checkOutput($sformatf("d%0d_busy_c%0d", d, c), (d == 0) ? int'(busy0) : int'(busy3), int'(e_busy));
      checkOutput($sformatf("d%0d_err_c%0d", d, c), (d == 0) ? int'(s_err0) : int'(s_err3), e_er);
      checkOutput($sformatf("d%0d_rdata_c%0d", d, c), (d == 0) ? int'(s_rdata0) : int'(s_rdata3), e_rd);
    end
  end

  task automatic drive(input int d, input logic req, input logic we, input int addr,
                       input logic [15:0] wd, input logic [1:0] be);
    if (d == 0) begin
      m_req0 = req; m_we0 = we; m_addr0 = 16'(addr); m_wdata0 = wd; m_be0 = be;
    end else begin
      m_req3 = req; m_we3 = we; m_addr3 = 16'(addr); m_wdata3 = wd; m_be3 = be;
    end
  endtask

  // Wait (bounded) for the ack, measuring latency from E0 and busy cycles
  task automatic pollAck(input int d, input int e0, output int lat, output logic [15:0] rd,
                         output logic er, output int bc);
    lat = -1;
    bc  = 0;
    rd  = '0;
    er  = 1'b0;
    for (int k = 0; k < 24 && lat < 0; k++) begin
      @(posedge clk); #1;
      if ((d == 0) ? busy0 : busy3) bc = bc + 1;
      if ((d == 0) ? s_ack0 : s_ack3) begin
        lat = cyc - e0 + 1;
        rd  = (d == 0) ? s_rdata0 : s_rdata3;
        er  = (d == 0) ? s_err0 : s_err3;
      end
    end
    if (lat < 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL ack_timeout d%0d: got no ack expected ack", d);
    end
  endtask

  // One master transaction. The request is dropped in the cycle after the
  // ack; with hold2 it stays up one more cycle so IDLE takes a second access.
  task automatic applyStimulus(input int d, input logic we, input int addr, input logic [15:0] wd,
                               input logic [1:0] be, input bit hold2, output int lat,
                               output logic [15:0] rd, output logic er, output int bc);
    int e0;
    @(posedge clk); #1;
    drive(d, 1'b1, we, addr, wd, be);
    e0 = cyc + 1;
    model_issue(d, we, addr, wd, be, e0);
    pollAck(d, e0, lat, rd, er, bc);
    @(posedge clk); #1;
    if (hold2) begin
      e0 = cyc + 1;
      model_issue(d, we, addr, wd, be, e0);
      pollAck(d, e0, lat, rd, er, bc);
      @(posedge clk); #1;
    end
    drive(d, 1'b0, 1'b0, 0, 16'h0, 2'b00);
  endtask

  initial begin
    int          lat, bc, e0;
    logic [15:0] rd;
    logic        er;
    model_reset(0);
    model_reset(1);
    #1;
    rst_n0 = 1'b0;
    rst_n3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ack0", s_ack0, 0);
    checkOutput("rst_busy0", busy0, 0);
    checkOutput("rst_rdata3", s_rdata3, 0);
    checkOutput("rst_err3", s_err3, 0);
    rst_n0 = 1'b1;
    rst_n3 = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] basic write/read, no wait states");
    applyStimulus(0, 1'b1, 8192, 16'h1234, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("wr8192_lat", lat, 1);
    checkOutput("wr8192_err", er, 0);
    applyStimulus(0, 1'b0, 8192, 16'h0, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("rd8192_lat", lat, 2);
    checkOutput("rd8192_data", rd, 16'h1234);
    checkOutput("rd8192_err", er, 0);
    checkOutput("rd8192_busy", bc, 2);

    $display("[TB] window edges and misses");
    applyStimulus(0, 1'b1, 8447, 16'hBEEF, 2'b11, 1'b0, lat, rd, er, bc);
    applyStimulus(0, 1'b0, 8447, 16'h0, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("rd8447_data", rd, 16'hBEEF);
    applyStimulus(0, 1'b0, 8448, 16'h0, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("rd8448_err", er, 1);
    checkOutput("rd8448_data", rd, 0);
    checkOutput("rd8448_lat", lat, 1);
    applyStimulus(0, 1'b0, 8191, 16'h0, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("rd8191_err", er, 1);
    checkOutput("rd8191_data", rd, 0);
    applyStimulus(0, 1'b1, 8448, 16'h5555, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("wr8448_err", er, 1);
    applyStimulus(0, 1'b0, 8447, 16'h0, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("rd8447_again", rd, 16'hBEEF);

    $display("[TB] byte enables");
    applyStimulus(0, 1'b1, 8200, 16'h1234, 2'b11, 1'b0, lat, rd, er, bc);
    applyStimulus(0, 1'b1, 8200, 16'hABCD, 2'b01, 1'b0, lat, rd, er, bc);
    applyStimulus(0, 1'b0, 8200, 16'h0, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("rd8200_be01", rd, 16'h12CD);
    applyStimulus(0, 1'b1, 8200, 16'hFFFF, 2'b00, 1'b0, lat, rd, er, bc);
    checkOutput("wr8200_be00_err", er, 1);
    applyStimulus(0, 1'b0, 8200, 16'h0, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("rd8200_after_be00", rd, 16'h12CD);
    checkOutput("rd8200_after_be00_err", er, 0);

    $display("[TB] request hold behaviour");
    applyStimulus(0, 1'b0, 8192, 16'h0, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("hold1_data", rd, 16'h1234);
    applyStimulus(0, 1'b0, 8447, 16'h0, 2'b11, 1'b1, lat, rd, er, bc);
    checkOutput("hold2_second_lat", lat, 2);
    checkOutput("hold2_second_data", rd, 16'hBEEF);

    $display("[TB] reset in READ");
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 8192, 16'h0, 2'b11);
    e0 = cyc + 1;
    model_issue(0, 1'b0, 8192, 16'h0, 2'b11, e0);
    @(posedge clk); #1;
    checkOutput("pre_rst_busy", busy0, 1);
    checkOutput("pre_rst_rdata", s_rdata0, 16'hBEEF);
    rst_n0 = 1'b0;
    drive(0, 1'b0, 1'b0, 0, 16'h0, 2'b00);
    model_reset(0);
    #1;
    checkOutput("mid_rst_ack", s_ack0, 0);
    checkOutput("mid_rst_busy", busy0, 0);
    checkOutput("mid_rst_rdata", s_rdata0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n0 = 1'b1;
    applyStimulus(0, 1'b0, 8192, 16'h0, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("post_rst_data", rd, 16'h1234);
    checkOutput("post_rst_lat", lat, 2);

    $display("[TB] three wait states");
    applyStimulus(1, 1'b1, 8192, 16'h5A5A, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("w3_wr_lat", lat, 4);
    checkOutput("w3_wr_busy", bc, 4);
    applyStimulus(1, 1'b0, 8192, 16'h0, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("w3_rd_lat", lat, 5);
    checkOutput("w3_rd_busy", bc, 5);
    checkOutput("w3_rd_data", rd, 16'h5A5A);
    applyStimulus(1, 1'b0, 9000, 16'h0, 2'b11, 1'b0, lat, rd, er, bc);
    checkOutput("w3_miss_lat", lat, 4);
    checkOutput("w3_miss_err", er, 1);

    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_ram_responder.md
# test_ram_responder

Bus slave that implements the TEST_RAM window of the system address map. It answers single-word read and write requests issued by any of the bus masters through the interconnect. Storage is an on-chip RAM of `SIZE` 16-bit words. An access outside the window, or a write with no byte enables, completes with an error response. An optional programmable wait-state counter lets the bench exercise master-side timeout and stall handling.

## Interface
Parameters:
- `BASE_ADDR`, 8192 — first word address of the window (TEST_RAM_OFFSET).
- `SIZE`, 256 — window size in words (TEST_RAM_SIZE); power of two, 2..4096.
- `ADDR_W`, 16 — bus word-address width.
- `DATA_W`, 16 — bus data width; fixed at 16.
- `WAIT_STATES`, 0 — extra cycles inserted before every response; 0..15.

Ports:
- `clk`  in  1  — single clock; all logic is on its rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `m_req`  in  1  — request; held high by the master until it sees `s_ack`.
- `m_we`  in  1  — 1 = write, 0 = read; valid while `m_req` is high.
- `m_addr`  in  `ADDR_W`  — absolute word address.
- `m_wdata`  in  16  — write data.
- `m_be`  in  2  — byte enables; bit 0 = [7:0], bit 1 = [15:8].
- `s_ack`  out  1  — one-cycle response strobe.
- `s_rdata`  out  16  — read data; valid while `s_ack` is high.
- `s_err`  out  1  — error flag; qualified by `s_ack`.
- `busy`  out  1  — high in every state except IDLE.

## Operation
- States: IDLE, WAIT, READ, RESP.
- **IDLE:** `m_req` is sampled here only. On `m_req` = 1, the block latches `m_we`, `m_addr`, `m_wdata` and `m_be`.
  - Offset calculation: `off = m_addr - BASE_ADDR`, computed at `ADDR_W` width.
  - Hit: `m_addr >= BASE_ADDR` and `off < SIZE`. RAM index = `off[$clog2(SIZE)-1:0]`.
- **IDLE → WAIT** if `WAIT_STATES > 0`, loading `ws_cnt = WAIT_STATES - 1`.
  - WAIT decrements `ws_cnt` each cycle.
  - WAIT exits when `ws_cnt == 0`, to READ for a read hit or to RESP otherwise.
- **IDLE → READ** for a read hit when `WAIT_STATES == 0`.
- **IDLE → RESP** for a write or a miss when `WAIT_STATES == 0`.
- **Write hit:** the RAM is written on the edge that enters RESP, byte-masked by `m_be`.
  - `m_be = 2'b00` is an error: `s_err` = 1 and no write occurs.
- **Read hit:** READ presents the address to the synchronous RAM. On the next edge, the RAM output is registered into `s_rdata` and the FSM enters RESP.
- **Miss** (below the base, or at or above `BASE_ADDR + SIZE`): no RAM access; `s_err` = 1, `s_rdata` = 0.
- **RESP:** `s_ack` = 1 for exactly one cycle, then the FSM returns to IDLE unconditionally. `m_req` is ignored while in RESP.
- **Output hold:** `s_rdata` and `s_err` hold their values until the next response. A write or a read miss loads `s_rdata` = 0.
- **Reset values:** `s_ack` = 0, `s_err` = 0, `s_rdata` = 0, `busy` = 0, state = IDLE, `ws_cnt` = 0.
  - RAM contents are not cleared by reset and survive it.
- **Reset mid-operation:** asserting `rst_n` low in any state drops `s_ack` and `busy` asynchronously.
  - An in-flight write either completes on the current edge or not at all; no partial bytes are written.

## Timing
- Let E0 be the edge at which IDLE samples `m_req` = 1, and W = `WAIT_STATES`.
- Write or miss: `s_ack` is high in the cycle after edge E0+W (latency 1+W).
- Read hit: `s_ack` is high in the cycle after edge E0+W+1 (latency 2+W).
- Master contract: the master deasserts `m_req` in the cycle following `s_ack`. IDLE then samples the deasserted request, so there is no double execution.
- Throughput: back-to-back requests with no bubble are not supported; minimum spacing is latency + 1 cycle.
- Combinational paths: none from inputs to `s_ack`, `s_rdata` or `s_err`; all outputs are registered.

## Test plan
- Write `m_addr`=8192, `m_wdata`=0x1234, `m_be`=11, then read 8192 → write ack at latency 1 with `s_err`=0; read ack at latency 2 with `s_rdata`=0x1234, `s_err`=0.
- Write 0xBEEF to 8447, then read 8447 → 0xBEEF. Read 8448 and read 8191 → `s_ack` with `s_err`=1, `s_rdata`=0, and the RAM is unchanged.
- Write 0x1234 to 8200, then write 0xABCD with `m_be`=01, then read 8200 → 0x12CD. A write with `m_be`=00 → `s_err`=1 and the data stays 0x12CD.
- With `WAIT_STATES`=3, read 8192 → `s_ack` 5 cycles after E0 and `busy` high for 5 cycles. A write → ack 4 cycles after E0.
- Hold `m_req` high through RESP and drop it the following cycle → exactly one access and one ack. Hold it two cycles longer → a second access, acked at its own latency.
- Drop `rst_n` in the READ state → `s_ack`, `busy` and `s_rdata` go to 0 immediately. After release, read 8192 → the value written before reset is returned.
